bp_me_wormhole_mem_cmd_tx: RTL and testbench
============================================

// Module: bp_me_wormhole_mem_cmd_tx
// PURPOSE
//  Multi-channel mem-command wormhole transmitter for the ME network. Round-robin arbitrates
//  num_chan_p mem_cmd sources, latches one command and computes wormhole len from msg_type/size.
//  Serialises packet {data, msg_hdr, src_cid, src_cord, len, cid, cord} (cord at LSB) into
//  flit_width_p flits. Sits between CCE/IO command sources and the mem NoC link.
// PARAMETERS
//  num_chan_p      2   number of input command channels (1..8)
//  flit_width_p    64  link flit width
//  cord_width_p    8   router coordinate width
//  cid_width_p     2   concentrator id width
//  len_width_p     4   wormhole len field width
//  msg_hdr_width_p 44  mem_cmd header width (no data)
//  block_width_p   512 data payload width (64 B max)
//  type_lsb_p      0   LSB of 4b msg_type in msg_hdr
//  size_lsb_p      4   LSB of 3b size in msg_hdr
// PORTS
//  clk_i           in   1                 clock
//  reset_n_i       in   1                 async active-low reset
//  cmd_hdr_i       in   C*msg_hdr_width_p per-channel header, ch k at [k*msg_hdr_width_p+:msg_hdr_width_p]
//  cmd_data_i      in   C*block_width_p   per-channel data, low bytes valid
//  cmd_dst_cord_i  in   C*cord_width_p    per-channel destination cord
//  cmd_dst_cid_i   in   C*cid_width_p     per-channel destination cid
//  cmd_v_i         in   C                 per-channel valid
//  cmd_ready_o     out  C                 per-channel ready (one-hot or zero)
//  src_cord_i      in   cord_width_p      this tile's cord (static)
//  src_cid_i       in   cid_width_p       this tile's cid (static)
//  link_data_o     out  flit_width_p      flit
//  link_v_o        out  1                 flit valid
//  link_ready_i    in   1                 link ready; flit moves when v & ready
// BEHAVIOUR
//  - H = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_hdr_width_p (68 default).
//  - Len: rd/uc_rd/pre -> CDIV(H,F)-1; wr/uc_wr -> CDIV(H+8*2^size,F)-1, size e_mem_size_1..64 = 0..6.
//    Size 7 or any other msg_type: illegal (see below). Len truncated to len_width_p.
//  - FSM IDLE/SEND. IDLE: grant = RR winner among cmd_v_i; cmd_ready_o[grant]=1; accept -> latch
//    packet, flit cnt=0, -> SEND. SEND: link_v_o=1, link_data_o = packet[cnt*F+:F] (zero-padded
//    above packet); each handshake cnt++. On handshake with cnt==len: if a cmd is valid, accept
//    it in the same cycle (back-to-back, no bubble), else -> IDLE.
//  - Latency: command accepted cycle N -> first flit valid cycle N+1. Throughput len+1 cycles/pkt.
//  - RR: priority pointer moves to grant+1 (mod C) after each accept; no channel starves.
//    Grant is held for whole packet (wormhole); cmd_ready_o is 0 during SEND except the last-flit cycle.
//  - cmd_ready_o does not depend on link_ready_i in IDLE; in SEND last-flit it does (comb path noted).
//  - Illegal cmd: accepted (ready=1), never sent, FSM stays/returns IDLE, pointer advances.
//  - Data beyond 8*2^size bits is not transmitted (len excludes it); bits above are don't-care.
//  - Reset (async, any time, incl. mid-packet): FSM=IDLE, cnt=0, RR pointer=0, link_v_o=0,
//    cmd_ready_o=0 while reset_n_i low; partial packet discarded, link must be reset together.
//  - link_data_o held stable while link_v_o=1 and link_ready_i=0.
// CONFIGURATION
//  BP_ME_WH_TX_ERR_CNT_EN defined: adds ports err_cnt_o out 16 (saturating count of dropped
//  illegal cmds, reset 0) and err_v_o out 1 (pulse 1 cycle per drop, reset 0).
//  Undefined: ports absent, illegal cmds dropped silently; all other behaviour identical.
// TESTING
//  1. Defaults, ch0 rd (type e_cce_mem_rd), link_ready=1 -> 2 flits, len=1, flit0[7:0]=dst_cord.
//  2. ch1 wr size=6 (64B) -> 10 flits, len=9; data bytes 0..63 at packet bit offset 68 onward.
//  3. ch0 uc_wr size=3 -> 3 flits len=2; link_ready toggled 1/0 each cycle -> flits held, none lost.
//  4. Both channels valid continuously, 4 rd each -> grants alternate 0,1,0,1..., no idle cycle
//     between packets.
//  5. msg_type illegal on ch0, then rd on ch0 -> no flits for first, rd sent; with
//     BP_ME_WH_TX_ERR_CNT_EN err_cnt_o=1, err_v_o one pulse.
//  6. reset_n_i low at flit 4 of 10-flit wr -> link_v_o=0 immediately; after release, new rd
//     sends 2 clean flits with cnt from 0.

Source files
------------

// File: rtl/bp_me_wormhole_mem_cmd_tx.sv
// Round-robin mem_cmd arbiter and wormhole flit serialiser for the ME network.
// Optional BP_ME_WH_TX_ERR_CNT_EN adds a saturating dropped-command counter.
module bp_me_wormhole_mem_cmd_tx #(
   parameter int num_chan_p      = 2,
   parameter int flit_width_p    = 64,
   parameter int cord_width_p    = 8,
   parameter int cid_width_p     = 2,
   parameter int len_width_p     = 4,
   parameter int msg_hdr_width_p = 44,
   parameter int block_width_p   = 512,
   parameter int type_lsb_p      = 0,
   parameter int size_lsb_p      = 4
) (
   input  logic                                    clk_i,
   input  logic                                    reset_n_i,
   input  logic [num_chan_p*msg_hdr_width_p-1:0]   cmd_hdr_i,
   input  logic [num_chan_p*block_width_p-1:0]     cmd_data_i,
   input  logic [num_chan_p*cord_width_p-1:0]      cmd_dst_cord_i,
   input  logic [num_chan_p*cid_width_p-1:0]       cmd_dst_cid_i,
   input  logic [num_chan_p-1:0]                   cmd_v_i,
   output logic [num_chan_p-1:0]                   cmd_ready_o,
   input  logic [cord_width_p-1:0]                 src_cord_i,
   input  logic [cid_width_p-1:0]                  src_cid_i,
   output logic [flit_width_p-1:0]                 link_data_o,
   output logic                                    link_v_o,
   input  logic                                    link_ready_i
`ifdef BP_ME_WH_TX_ERR_CNT_EN
  ,output logic [15:0]                             err_cnt_o
  ,output logic                                    err_v_o
`endif
);

   localparam int C  = num_chan_p;
   localparam int F  = flit_width_p;
   localparam int HW = msg_hdr_width_p;
   localparam int BW = block_width_p;
   localparam int CW = cord_width_p;
   localparam int IW = cid_width_p;
   localparam int L  = len_width_p;
   localparam int H  = 2*CW + 2*IW + L + HW;
   localparam int P  = H + BW;
   localparam int NF = (P + F - 1) / F;
   localparam int PW = (C > 1) ? $clog2(C) : 1;

   localparam logic [3:0] T_RD   = 4'd0;
   localparam logic [3:0] T_WR   = 4'd1;
   localparam logic [3:0] T_UCRD = 4'd2;
   localparam logic [3:0] T_UCWR = 4'd3;
   localparam logic [3:0] T_PRE  = 4'd4;

   typedef enum logic {S_IDLE, S_SEND} state_e;

   state_e          state_q, state_d;
   logic [L-1:0]    cnt_q, cnt_d;
   logic [L-1:0]    len_q, len_d;
   logic [P-1:0]    pkt_q, pkt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   gidx;
   logic            found;
   int              k;

   logic [HW-1:0]   sel_hdr;
   logic [BW-1:0]   sel_data;
   logic [CW-1:0]   sel_cord;
   logic [IW-1:0]   sel_cid;
   logic [3:0]      sel_type;
   logic [2:0]      sel_size;
   logic [L-1:0]    sel_len;
   logic            is_rd, is_wr, legal;
   int              bits, flits;

   logic            last, accept_en, accept;
   logic [NF*F-1:0] pad;

   // First valid channel at or after the priority pointer
   always_comb begin
      gidx  = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < C; i++) begin
         k = (int'(ptr_q) + i) % C;
         if (!found && cmd_v_i[k]) begin
            found = 1'b1;
            gidx  = PW'(k);
         end
      end
   end

   always_comb begin
      sel_hdr  = cmd_hdr_i[int'(gidx)*HW +: HW];
      sel_data = cmd_data_i[int'(gidx)*BW +: BW];
      sel_cord = cmd_dst_cord_i[int'(gidx)*CW +: CW];
      sel_cid  = cmd_dst_cid_i[int'(gidx)*IW +: IW];
      sel_type = sel_hdr[type_lsb_p +: 4];
      sel_size = sel_hdr[size_lsb_p +: 3];
      is_rd    = (sel_type == T_RD) || (sel_type == T_UCRD)
              || (sel_type == T_PRE);
      is_wr    = (sel_type == T_WR) || (sel_type == T_UCWR);
      legal    = (sel_size != 3'd7);
      bits     = H;
      unique case (1'b1)
         is_rd:   bits = H;
         is_wr:   bits = H + (8 << sel_size);
         default: legal = 1'b0;
      endcase
      flits   = (bits + F - 1) / F;
      sel_len = L'(flits - 1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         pkt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pkt_q   <= pkt_d;
         ptr_q   <= ptr_d;
      end
   end

   // Last-flit handshake reopens acceptance for a bubble-free handoff
   always_comb begin
      last      = (state_q == S_SEND) && (cnt_q == len_q);
      accept_en = (state_q == S_IDLE) || (last && link_ready_i);
      accept    = accept_en && found;
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      pkt_d     = pkt_q;
      ptr_d     = ptr_q;
      if ((state_q == S_SEND) && link_ready_i) begin
         if (last) state_d = S_IDLE;
         else      cnt_d   = cnt_q + 1'b1;
      end
      if (accept) begin
         ptr_d = PW'((int'(gidx) + 1) % C);
         if (legal) begin
            state_d = S_SEND;
            cnt_d   = '0;
            len_d   = sel_len;
            pkt_d   = {sel_data, sel_hdr, src_cid_i, src_cord_i,
                       sel_len, sel_cid, sel_cord};
         end
      end
   end

   always_comb begin
      pad          = '0;
      pad[P-1:0]   = pkt_q;
      link_v_o     = (state_q == S_SEND);
      link_data_o  = pad[int'(cnt_q)*F +: F];
      cmd_ready_o  = '0;
      if (reset_n_i && accept_en && found)
         cmd_ready_o[gidx] = 1'b1;
   end

`ifdef BP_ME_WH_TX_ERR_CNT_EN
   logic        drop;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        err_v_q, err_v_d;

   always_comb begin
      drop      = accept && !legal;
      err_v_d   = drop;
      err_cnt_d = err_cnt_q;
      if (drop && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_cnt_q <= '0;
         err_v_q   <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         err_v_q   <= err_v_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
   assign err_v_o   = err_v_q;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_mem_cmd_tx.sv
// Directed bench for the mem_cmd wormhole transmitter.
// Build with BP_ME_WH_TX_ERR_CNT_EN to also cover the error counter.
module tb_bp_me_wormhole_mem_cmd_tx;

   localparam logic [7:0] SRC_CORD = 8'h77;
   localparam logic [1:0] SRC_CID  = 2'd3;

   logic           clk_i = 1'b0;
   logic           reset_n_i;
   logic [87:0]    cmd_hdr_i = '0;
   logic [1023:0]  cmd_data_i = '0;
   logic [15:0]    cmd_dst_cord_i = '0;
   logic [3:0]     cmd_dst_cid_i = '0;
   logic [1:0]     cmd_v_i = '0;
   logic [1:0]     cmd_ready_o;
   logic [7:0]     src_cord_i = SRC_CORD;
   logic [1:0]     src_cid_i = SRC_CID;
   logic [63:0]    link_data_o;
   logic           link_v_o;
   logic           link_ready_i = 1'b1;
`ifdef BP_ME_WH_TX_ERR_CNT_EN
   logic [15:0]    err_cnt_o;
   logic           err_v_o;
`endif

   bp_me_wormhole_mem_cmd_tx dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .cmd_hdr_i(cmd_hdr_i), .cmd_data_i(cmd_data_i),
      .cmd_dst_cord_i(cmd_dst_cord_i), .cmd_dst_cid_i(cmd_dst_cid_i),
      .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
      .src_cord_i(src_cord_i), .src_cid_i(src_cid_i),
      .link_data_o(link_data_o), .link_v_o(link_v_o),
      .link_ready_i(link_ready_i)
`ifdef BP_ME_WH_TX_ERR_CNT_EN
     ,.err_cnt_o(err_cnt_o), .err_v_o(err_v_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] typ;
      logic [2:0] size;
      int         ch;
      logic [7:0] cord;
      logic [1:0] cid;
      logic [3:0] len;
      int         nflit;
      int         nbytes;
      bit         tog;
   } vec_t;

   vec_t        vt[12];
   int          tests = 0;
   int          fails = 0;
   int          nflits;
   int          acc_cyc, first_cyc;
   logic [63:0] flits[16];
`ifdef BP_ME_WH_TX_ERR_CNT_EN
   int          exp_err = 0;
   int          pulses;
`endif

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [43:0] mk_hdr(input logic [3:0] t,
                                          input logic [2:0] s);
      return {37'h1_5A5A_C3C3, s, t};
   endfunction

   function automatic logic [511:0] mk_data(input int nb);
      logic [511:0] d;
      d = '0;
      for (int i = 0; i < 64; i++)
         if (i < nb) d[i*8 +: 8] = 8'(i + 1);
      return d;
   endfunction

   function automatic logic [639:0] mk_pkt(input logic [43:0] h,
      input logic [511:0] d, input logic [7:0] cord,
      input logic [1:0] cid, input logic [3:0] len);
      logic [639:0] p;
      p = '0;
      p[579:0] = {d, h, SRC_CID, SRC_CORD, len, cid, cord};
      return p;
   endfunction

   task automatic set_chan(input int ch, input logic [43:0] h,
      input logic [511:0] d, input logic [7:0] cord,
      input logic [1:0] cid);
      cmd_hdr_i[ch*44 +: 44]     = h;
      cmd_data_i[ch*512 +: 512]  = d;
      cmd_dst_cord_i[ch*8 +: 8]  = cord;
      cmd_dst_cid_i[ch*2 +: 2]   = cid;
   endtask

   task automatic run_cmd(input vec_t v);
      int cyc, idle;
      bit acc, done, hold;
      logic [63:0] prev;
      logic [639:0] rp;
      nflits = 0; acc_cyc = -1; first_cyc = -1;
      acc = 0; done = 0; hold = 0; idle = 0; prev = '0; cyc = 0;
`ifdef BP_ME_WH_TX_ERR_CNT_EN
      pulses = 0;
`endif
      set_chan(v.ch, mk_hdr(v.typ, v.size), mk_data(v.nbytes),
               v.cord, v.cid);
      cmd_v_i = 2'(1 << v.ch);
      while (!done && cyc < 200) begin
         link_ready_i = v.tog ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk_i);
         if (hold) begin
            chk("hold_v", 64'(link_v_o), 64'd1);
            chk("hold_data", link_data_o, prev);
         end
         if (acc && link_v_o && first_cyc < 0) first_cyc = cyc;
         if (!acc && cmd_v_i[v.ch] && cmd_ready_o[v.ch]) begin
            acc = 1; acc_cyc = cyc;
         end
         if (link_v_o && link_ready_i && nflits < 16) begin
            flits[nflits] = link_data_o;
            nflits++;
         end
         hold = link_v_o && !link_ready_i;
         prev = link_data_o;
`ifdef BP_ME_WH_TX_ERR_CNT_EN
         if (err_v_o) pulses++;
`endif
         if (acc && cyc > acc_cyc && !link_v_o) begin
            if (nflits > 0) done = 1;
            else begin
               idle++;
               if (idle >= 3) done = 1;
            end
         end
         @(posedge clk_i); #1;
         if (acc) cmd_v_i = '0;
         cyc++;
      end
      link_ready_i = 1'b1;
      chk("run_done", 64'(done), 64'd1);
      chk("nflits", 64'(nflits), 64'(v.nflit));
      rp = mk_pkt(mk_hdr(v.typ, v.size), mk_data(v.nbytes),
                  v.cord, v.cid, v.len);
      if (v.nflit > 0) begin
         chk("latency", 64'(first_cyc), 64'(acc_cyc + 1));
         chk("flit0_cord", 64'(flits[0][7:0]), 64'(v.cord));
         chk("flit0_len", 64'(flits[0][13:10]), 64'(v.len));
      end
      for (int i = 0; i < nflits && i < v.nflit; i++)
         chk($sformatf("flit%0d", i), flits[i], rp[i*64 +: 64]);
`ifdef BP_ME_WH_TX_ERR_CNT_EN
      if (v.nflit == 0) exp_err++;
      chk("err_pulses", 64'(pulses), 64'(v.nflit == 0));
      chk("err_cnt", 64'(err_cnt_o), 64'(exp_err));
`endif
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      reset_n_i = 1'b1;
`ifdef BP_ME_WH_TX_ERR_CNT_EN
      exp_err = 0;
`endif
   endtask

   initial begin
      int ng, gap, nf, rem[2];
      int grants[8];
      logic [7:0] gc;

      vt[0]  = '{4'd0, 3'd0, 0, 8'h35, 2'd1, 4'd1, 2,  0,  1'b0};
      vt[1]  = '{4'd1, 3'd6, 1, 8'h5A, 2'd2, 4'd9, 10, 64, 1'b0};
      vt[2]  = '{4'd3, 3'd3, 0, 8'hC1, 2'd0, 4'd2, 3,  8,  1'b1};
      vt[3]  = '{4'd2, 3'd1, 1, 8'h0F, 2'd3, 4'd1, 2,  0,  1'b0};
      vt[4]  = '{4'd4, 3'd0, 0, 8'h81, 2'd1, 4'd1, 2,  0,  1'b0};
      vt[5]  = '{4'd1, 3'd0, 1, 8'h42, 2'd2, 4'd1, 2,  1,  1'b0};
      vt[6]  = '{4'd1, 3'd2, 0, 8'h13, 2'd0, 4'd1, 2,  4,  1'b0};
      vt[7]  = '{4'd3, 3'd4, 1, 8'hE7, 2'd1, 4'd3, 4,  16, 1'b1};
      vt[8]  = '{4'd1, 3'd5, 0, 8'h99, 2'd3, 4'd5, 6,  32, 1'b0};
      vt[9]  = '{4'd9, 3'd0, 0, 8'h21, 2'd0, 4'd0, 0,  0,  1'b0};
      vt[10] = '{4'd1, 3'd7, 0, 8'h22, 2'd0, 4'd0, 0,  0,  1'b0};
      vt[11] = '{4'd0, 3'd0, 0, 8'h3C, 2'd2, 4'd1, 2,  0,  1'b0};

      reset_n_i = 1'b0;
      cmd_v_i = 2'b11;
      #3;
      chk("rst_link_v", 64'(link_v_o), 64'd0);
      chk("rst_ready", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i); @(posedge clk_i); #1;
      cmd_v_i = '0;
      reset_n_i = 1'b1;
      #1;
      chk("idle_ready0", 64'(cmd_ready_o), 64'd0);
      chk("idle_link_v", 64'(link_v_o), 64'd0);
`ifdef BP_ME_WH_TX_ERR_CNT_EN
      chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
      chk("rst_err_v", 64'(err_v_o), 64'd0);
`endif
      cmd_v_i = 2'b01; link_ready_i = 1'b0; #1;
      chk("idle_ready_lr0", 64'(cmd_ready_o), 64'd1);
      link_ready_i = 1'b1; #1;
      chk("idle_ready_lr1", 64'(cmd_ready_o), 64'd1);
      cmd_v_i = 2'b10; #1;
      chk("idle_ready_ch1", 64'(cmd_ready_o), 64'd2);
      cmd_v_i = '0;
      @(posedge clk_i); #1;

      for (int i = 0; i < 12; i++) run_cmd(vt[i]);

      // Both channels streaming reads: grants alternate, no bubbles
      do_reset();
      cmd_data_i = '0;
      set_chan(0, mk_hdr(4'd0, 3'd0), '0, 8'h11, 2'd0);
      set_chan(1, mk_hdr(4'd0, 3'd0), '0, 8'h22, 2'd1);
      rem[0] = 4; rem[1] = 4; ng = 0; gap = 0; nflits = 0;
      cmd_v_i = 2'b11;
      for (int c = 0; c < 200 && nflits < 16; c++) begin
         @(negedge clk_i);
         chk("rr_onehot", 64'(cmd_ready_o == 2'b11), 64'd0);
         for (int j = 0; j < 2; j++)
            if (cmd_v_i[j] && cmd_ready_o[j] && ng < 8) begin
               grants[ng] = j; ng++; rem[j]--;
            end
         if (link_v_o) begin
            flits[nflits] = link_data_o;
            nflits++;
         end else if (nflits > 0) gap++;
         @(posedge clk_i); #1;
         for (int j = 0; j < 2; j++)
            if (rem[j] == 0) cmd_v_i[j] = 1'b0;
      end
      cmd_v_i = '0;
      chk("rr_grants", 64'(ng), 64'd8);
      chk("rr_flits", 64'(nflits), 64'd16);
      chk("rr_gap", 64'(gap), 64'd0);
      for (int i = 0; i < ng; i++) begin
         gc = (i % 2 == 1) ? 8'h22 : 8'h11;
         chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
         if (2*i < nflits)
            chk($sformatf("rr_cord%0d", i), 64'(flits[2*i][7:0]), 64'(gc));
      end
      @(posedge clk_i); #1;

      // Reset in the middle of a 10-flit write
      set_chan(1, mk_hdr(4'd1, 3'd6), mk_data(64), 8'h5A, 2'd2);
      cmd_v_i = 2'b10; nf = 0;
      for (int c = 0; c < 50 && nf < 4; c++) begin
         @(negedge clk_i);
         if (link_v_o && link_ready_i) nf++;
         @(posedge clk_i); #1;
         cmd_v_i = '0;
      end
      chk("mid_flits", 64'(nf), 64'd4);
      chk("mid_v_before", 64'(link_v_o), 64'd1);
      reset_n_i = 1'b0;
      cmd_v_i = 2'b11;
      #1;
      chk("mid_rst_v", 64'(link_v_o), 64'd0);
      chk("mid_rst_ready", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i); @(posedge clk_i); #1;
      cmd_v_i = '0;
      reset_n_i = 1'b1;
`ifdef BP_ME_WH_TX_ERR_CNT_EN
      exp_err = 0;
`endif
      #1;
      chk("post_rst_v", 64'(link_v_o), 64'd0);
      @(posedge clk_i); #1;
      run_cmd(vt[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
